// File: rtl/axis_stream_checker_pkg.sv
// Shared types, constants and helpers for the AXI-Stream checker.
package axis_chk_pkg;

  // Checker control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_t;

  // Stall LFSR: x^16 + x^14 + x^13 + x^11 + 1, Fibonacci, shift left.
  // Taps sit on bits 15, 13, 12 and 10; their XOR feeds bit 0.
  localparam int          LFSR_WIDTH = 16;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // The compare helper works on a fixed maximum width; callers zero-extend.
  // Extended lanes carry keep=0 and therefore never flag a mismatch.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_KEEP_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

  // Returns 1 when any byte enabled by keep differs between data_a and data_b.
  function automatic logic keep_mask_cmp(
    input logic [MAX_DATA_WIDTH-1:0] data_a,
    input logic [MAX_DATA_WIDTH-1:0] data_b,
    input logic [MAX_KEEP_WIDTH-1:0] keep
  );
    logic mismatch;
    mismatch = 1'b0;
    for (int b = 0; b < MAX_KEEP_WIDTH; b++) begin
      if (keep[b] && (data_a[8*b +: 8] != data_b[8*b +: 8])) begin
        mismatch = 1'b1;
      end
    end
    return mismatch;
  endfunction

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI-Stream bundle used for both the expected and the DUT stream.
interface axis_stream_checker_if #(
  parameter int DATA_WIDTH = 128
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_stream_checker_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head.
// The head is read combinationally so it can be compared against a beat in
// the same cycle the beat is accepted. A write is allowed while full if a
// read happens in the same cycle, leaving occupancy unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Read/write pointers with an extra wrap bit for full/empty detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink comparing a DUT stream against buffered expected beats.
// Backpressure on the DUT side comes from a free-running LFSR so the stall
// pattern is deterministic per seed and usable in hardware soak tests.
module axis_stream_checker
  import axis_chk_pkg::*;
#(
  parameter int          DATA_WIDTH  = 128,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_STALL   = 15,
  parameter int          STOP_ON_ERR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [7:0]            stall_thresh,
  axis_stream_checker_if.slave  exp_axis,
  axis_stream_checker_if.slave  s_axis,
  output logic [31:0]           word_idx,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           err_cnt,
  output logic                  err_data,
  output logic                  err_early_last,
  output logic                  err_late_last,
  output logic [31:0]           first_err_idx,
  output logic                  halted
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int FW = DATA_WIDTH + KW + 1;

  chk_state_t        state_reg, state_next;
  logic [15:0]       lfsr_reg, lfsr_next;
  logic [15:0]       stall_run_reg, stall_run_next;

  logic [FW-1:0]     fifo_head;
  logic              fifo_full, fifo_empty;
  logic              fifo_wr;
  logic              exp_ready;
  logic              s_ready;
  logic              stall;
  logic              accept;

  logic                  head_last;
  logic [KW-1:0]         head_keep;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  data_mm, early_last, late_last, beat_err;

  logic [31:0] word_idx_reg, pkt_cnt_reg, first_err_idx_reg;
  logic [15:0] err_cnt_reg;
  logic        err_data_reg, err_early_last_reg, err_late_last_reg;

  // Expected side: FIFO not-full, held low while reset is asserted.
  assign exp_ready       = ~fifo_full & rst_n;
  assign exp_axis.tready = exp_ready;
  assign fifo_wr         = exp_axis.tvalid & exp_ready;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({exp_axis.tlast, exp_axis.tkeep, exp_axis.tdata}),
    .rd_en   (accept),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_last = fifo_head[FW-1];
  assign head_keep = fifo_head[DATA_WIDTH +: KW];
  assign head_data = fifo_head[DATA_WIDTH-1:0];

  // Stall is capped by the run counter so tready is forced high eventually.
  assign stall   = (lfsr_reg[7:0] < stall_thresh) & (stall_run_reg < 16'(MAX_STALL));
  assign s_ready = (state_reg == RUN) & ~fifo_empty & ~stall;
  assign s_axis.tready = s_ready;
  assign accept  = s_axis.tvalid & s_ready;

  // Beat classification against the FIFO head; bytes with expected keep=0
  // are ignored, but any keep difference is itself a data error.
  assign data_mm = keep_mask_cmp(MAX_DATA_WIDTH'(s_axis.tdata),
                                 MAX_DATA_WIDTH'(head_data),
                                 MAX_KEEP_WIDTH'(head_keep))
                 | (s_axis.tkeep != head_keep);
  assign early_last = s_axis.tlast & ~head_last;
  assign late_last  = head_last & ~s_axis.tlast;
  assign beat_err   = data_mm | early_last | late_last;

  // Next-state logic for the control FSM, LFSR and stall-run counter.
  always_comb begin
    state_next     = state_reg;
    lfsr_next      = lfsr_reg;
    stall_run_next = '0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        lfsr_next = {lfsr_reg[14:0], lfsr_feedback(lfsr_reg)};
        if (~fifo_empty && stall) stall_run_next = stall_run_reg + 16'd1;
        if ((STOP_ON_ERR != 0) && accept && beat_err) state_next = HALT;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, LFSR and stall-run registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lfsr_reg      <= LFSR_SEED;
      stall_run_reg <= '0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      stall_run_reg <= stall_run_next;
    end
  end

  // Counters and sticky error flags, updated on each accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_idx_reg       <= '0;
      pkt_cnt_reg        <= '0;
      err_cnt_reg        <= '0;
      err_data_reg       <= 1'b0;
      err_early_last_reg <= 1'b0;
      err_late_last_reg  <= 1'b0;
      first_err_idx_reg  <= 32'hFFFF_FFFF;
    end else if (accept) begin
      word_idx_reg <= word_idx_reg + 32'd1;
      if (head_last) pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      if (beat_err) begin
        if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
        if (first_err_idx_reg == 32'hFFFF_FFFF) first_err_idx_reg <= word_idx_reg;
      end
      if (data_mm)    err_data_reg       <= 1'b1;
      if (early_last) err_early_last_reg <= 1'b1;
      if (late_last)  err_late_last_reg  <= 1'b1;
    end
  end

  assign word_idx       = word_idx_reg;
  assign pkt_cnt        = pkt_cnt_reg;
  assign err_cnt        = err_cnt_reg;
  assign err_data       = err_data_reg;
  assign err_early_last = err_early_last_reg;
  assign err_late_last  = err_late_last_reg;
  assign first_err_idx  = first_err_idx_reg;
  assign halted         = (state_reg == HALT);

endmodule

// File: doc/axis_stream_checker.md
Name: axis_stream_checker

Overview:
- Synthesizable successor to the file-driven ciphertext consumer: an AXI-Stream sink that compares a DUT output stream against an expected stream beat-by-beat.
- Expected beats arrive on a second AXI-Stream port and are buffered in an internal FIFO.
- Sink backpressure comes from an on-chip LFSR instead of delay files, so the checker runs in FPGA soak tests as well as simulation.
- Sits after the AES-256-CTR core output. Reports word/packet counts, error classes and the first failing index.

Parameters:
- DATA_WIDTH, 128, data width in bits; must be a multiple of 8.
- FIFO_DEPTH, 16, expected-beat buffer depth; must be a power of two and at least 2.
- LFSR_SEED, 16'hACE1, reset seed of the 16-bit stall LFSR; must be nonzero.
- MAX_STALL, 15, maximum number of consecutive stalled cycles before tready is forced high.
- STOP_ON_ERR, 1, if 1 the checker halts on the first error; if 0 it counts errors and keeps running.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  starts the checker; sampled only in IDLE
- stall_thresh  in  8  stall when lfsr[7:0] < stall_thresh; 0 means never stall
- exp_axis_tdata  in  DATA_WIDTH  expected data
- exp_axis_tkeep  in  DATA_WIDTH/8  expected byte enables
- exp_axis_tlast  in  1  expected end of packet
- exp_axis_tvalid  in  1  expected beat valid
- exp_axis_tready  out  1  FIFO not full
- s_axis_tdata  in  DATA_WIDTH  DUT data
- s_axis_tkeep  in  DATA_WIDTH/8  DUT byte enables
- s_axis_tlast  in  1  DUT end of packet
- s_axis_tvalid  in  1  DUT beat valid
- s_axis_tready  out  1  checker ready for a DUT beat
- word_idx  out  32  DUT beats accepted
- pkt_cnt  out  32  packets completed
- err_cnt  out  16  errors counted; saturates at 16'hFFFF
- err_data  out  1  sticky: data or keep mismatch
- err_early_last  out  1  sticky: DUT tlast=1 while expected tlast=0
- err_late_last  out  1  sticky: expected tlast=1 while DUT tlast=0
- first_err_idx  out  32  word_idx at the first error
- halted  out  1  high in state HALT

Behaviour:
- Reset is synchronous on rst_n=0 at a clk edge:
  - all outputs are 0, except first_err_idx, which is 32'hFFFF_FFFF;
  - the FIFO is emptied, the LFSR is loaded with LFSR_SEED, and the state goes to IDLE.
  - A reset mid-packet discards FIFO contents and all counters.
- States:
  - IDLE: waits until enable=1, then goes to RUN.
  - RUN: checks beats. On the first error with STOP_ON_ERR=1, goes to HALT.
  - HALT: s_axis_tready=0; FIFO still accepts writes; only reset exits.
- exp_axis_tready is the FIFO not-full flag, in every state.
  - An expected beat is written when exp_axis_tvalid and exp_axis_tready are both 1.
  - A write and a read in the same cycle are allowed when the FIFO is full; occupancy is then unchanged.
- s_axis_tready = (state==RUN) & FIFO non-empty & ~stall.
  - stall = (lfsr[7:0] < stall_thresh) & (stall_run < MAX_STALL).
  - stall_run counts consecutive cycles in RUN with FIFO non-empty and stall=1; it clears on any non-stalled cycle.
- The LFSR advances every cycle in RUN.
  - Polynomial: x^16+x^14+x^13+x^11+1, Fibonacci form, shift left, feedback into bit 0.
  - It is independent of tvalid, so the stall pattern is deterministic per seed.
- A DUT beat is accepted when s_axis_tvalid and s_axis_tready are both 1. The FIFO head is popped in the same cycle.
- Comparison is combinational on the FIFO head against the accepted beat. Results are registered, so outputs update one cycle after acceptance.
  - data mismatch: any byte b where exp_keep[b]=1 and the data bytes differ, OR s_keep != exp_keep.
  - Bytes with exp_keep[b]=0 are ignored.
  - early last: s_tlast=1 and exp_tlast=0. late last: exp_tlast=1 and s_tlast=0.
- A beat can raise several error flags, but err_cnt increments by at most 1 per beat.
  - first_err_idx is written only while it still holds all ones.
- word_idx increments on every accepted beat.
- pkt_cnt increments on an accepted beat with exp_tlast=1, even if that beat has errors.
- The DUT tvalid and data inputs are ignored whenever tready=0; no check is made for dropped or held data.

Decomposition:
- Package axis_chk_pkg holds:
  - state typedef chk_state_t {IDLE, RUN, HALT};
  - LFSR tap constant;
  - function keep_mask_cmp(data_a, data_b, keep) returning the mismatch flag.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) stores {tlast, tkeep, tdata}. It provides full, empty and same-cycle read/write.

Test Plan:
- stall_thresh=0; 3 packets of 4 identical beats -> s_axis_tready held 1 throughout; word_idx=12; pkt_cnt=3; err_cnt=0; first_err_idx=FFFF_FFFF.
- stall_thresh=8'hFF; 64 identical beats -> no stall run longer than 15 cycles; all 64 beats accepted; err_cnt=0.
- STOP_ON_ERR=1; beat 5 data has byte 3 flipped -> err_data=1; first_err_idx=5; halted=1; s_axis_tready=0 afterwards; word_idx=6.
- STOP_ON_ERR=0; DUT tlast on beat 2 of a 4-beat packet, tlast missing on beat 3 -> err_early_last=1; err_late_last=1; err_cnt=2; first_err_idx=2.
- exp_keep=16'h00FF; DUT upper 8 bytes are garbage with matching keep -> no error. Same stimulus with DUT keep=16'h01FF -> err_data=1.
- Expected side writes 20 beats with the DUT idle, then reset mid-stream -> exp_axis_tready=0 at 16 occupancy; after reset all counters are 0 and the FIFO is empty.
